mult_ctrl_n: RTL and testbench

Parametrised sequencer for the shift-add signed multiplier. It drives the A/B register pair, the X sign flop and the adder/subtractor for a WIDTH-bit two's-complement multiply. The per-step unrolled states of the 8-bit controller are replaced by a loop counter, and the block adds Busy/Done status plus an optional Booth mode. It sits between the synchronised front-panel inputs and the multiplier datapath.

---
 rtl/mult_ctrl_pkg.sv | 19 +
 rtl/mult_step_cnt.sv | 43 ++++
 rtl/mult_ctrl_n.sv | 158 +++++++++++++++
 tb/tb_mult_ctrl_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_ctrl_pkg
// Shared types and limits for the shift-add signed multiplier sequencer.
//   mult_state_t   : controller state encoding (IDLE, CLEAR, OP, SHIFT, DONE)
//   MULT_MAX_WIDTH : largest supported operand width
// -----------------------------------------------------------------------------
package mult_ctrl_pkg;

  localparam int unsigned MULT_MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    OP    = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

endpackage : mult_ctrl_pkg

// File: rtl/mult_step_cnt.sv
// -----------------------------------------------------------------------------
// mult_step_cnt
// Step counter for the multiply loop. Counts 0..WIDTH-1 and flags the final
// step so the controller knows when the last shift has happened.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset (count -> 0)
//   clr   in   synchronous clear to 0
//   inc   in   advance the count by one
//   step  out  current count (CNT_W bits)
//   last  out  count equals WIDTH-1
// -----------------------------------------------------------------------------
module mult_step_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] step,
  output logic             last
);

  logic [CNT_W-1:0] step_r;

  // Step register: reset and clear both return to 0, clear has priority over inc
  always_ff @(posedge clk) begin
    if (reset) begin
      step_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      step_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      step_r <= step_r + CNT_W'(1);
    end else begin
      step_r <= step_r;
    end
  end

  assign step = step_r;
  assign last = (step_r == CNT_W'(WIDTH - 32'd1));

endmodule : mult_step_cnt

// File: rtl/mult_ctrl_n.sv
// -----------------------------------------------------------------------------
// mult_ctrl_n
// Sequencer for a WIDTH-bit two's-complement shift-add multiplier. Drives the
// A/B register pair, the X sign flop and the adder/subtractor, with one
// OP/SHIFT pair per operand bit and Busy/Done status.
// Compile-time option: define MULT_CTRL_BOOTH_EN for radix-2 Booth recoding
// of (M, M_prev) in every OP step; otherwise plain shift-add with a
// subtract on the final (sign) step and M_prev unused.
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset; forces all outputs to 0
//   ClearA_LoadB in   clear A/X and load B (honoured in IDLE only)
//   Run          in   level start request, one multiply per assertion
//   M            in   current multiplier LSB
//   M_prev       in   previously shifted-out bit (Booth mode only)
//   Clr_Ld       out  clear A/X and load B
//   Clr_XA       out  clear X and A before a run
//   Add          out  A <= A + S
//   Sub          out  A <= A - S
//   Shift_En     out  arithmetic right shift of X:A:B
//   Busy         out  multiply in progress (CLEAR, OP, SHIFT)
//   Done         out  result valid in X:A:B
//   Step         out  current step index
// -----------------------------------------------------------------------------
module mult_ctrl_n
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic             M,
  input  logic             M_prev,
  output logic             Clr_Ld,
  output logic             Clr_XA,
  output logic             Add,
  output logic             Sub,
  output logic             Shift_En,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Step
);

  mult_state_t      state_r;
  mult_state_t      next_state_s;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             last_s;
  logic [CNT_W-1:0] step_s;

`ifndef MULT_CTRL_BOOTH_EN
  // M_prev only matters for Booth recoding
  logic unused_m_prev_s;
  assign unused_m_prev_s = M_prev;
`endif

  mult_step_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clk   (Clk),
    .reset (Reset),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .step  (step_s),
    .last  (last_s)
  );

  // State register with synchronous reset to IDLE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; Reset masks every output combinationally
  always_comb begin
    next_state_s = state_r;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    Clr_Ld       = 1'b0;
    Clr_XA       = 1'b0;
    Add          = 1'b0;
    Sub          = 1'b0;
    Shift_En     = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    Step         = step_s;

    if (Reset) begin
      next_state_s = IDLE;
      Step         = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // Load request wins over Run when both are high
          if (ClearA_LoadB) begin
            Clr_Ld = 1'b1;
          end else if (Run) begin
            next_state_s = CLEAR;
          end else begin
            next_state_s = IDLE;
          end
        end
        CLEAR: begin
          Clr_XA       = 1'b1;
          Busy         = 1'b1;
          cnt_clr_s    = 1'b1;
          next_state_s = OP;
        end
        OP: begin
          Busy = 1'b1;
`ifdef MULT_CTRL_BOOTH_EN
          // Radix-2 Booth: 01 -> +S, 10 -> -S, 00/11 -> nothing
          Add = ~M & M_prev;
          Sub = M & ~M_prev;
`else
          // Sign bit of the multiplier carries negative weight
          if (last_s) begin
            Sub = M;
          end else begin
            Add = M;
          end
`endif
          next_state_s = SHIFT;
        end
        SHIFT: begin
          Shift_En = 1'b1;
          Busy     = 1'b1;
          if (last_s) begin
            next_state_s = DONE;
          end else begin
            cnt_inc_s    = 1'b1;
            next_state_s = OP;
          end
        end
        DONE: begin
          Done = 1'b1;
          // Wait for Run to drop so a held button gives a single multiply
          if (Run) begin
            next_state_s = DONE;
          end else begin
            next_state_s = IDLE;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

endmodule : mult_ctrl_n

// File: tb/tb_mult_ctrl_n.sv
// -----------------------------------------------------------------------------
// tb_mult_ctrl_n
// Directed bench for mult_ctrl_n at WIDTH = 2, 4, 8 and 16. All instances share
// the input stimulus; each test checks one instance cycle by cycle against
// hand-derived expectations. Output vectors are packed as
// {Clr_Ld, Clr_XA, Add, Sub, Shift_En, Busy, Done}.
// -----------------------------------------------------------------------------
module tb_mult_ctrl_n;

  logic Clk;
  logic Reset;
  logic ClearA_LoadB;
  logic Run;
  logic M;
  logic M_prev;

  logic [6:0] outs2, outs4, outs8, outs16;
  logic [0:0] step2;
  logic [1:0] step4;
  logic [2:0] step8;
  logic [3:0] step16;

  int errs;
  int checks;

  mult_ctrl_n #(.WIDTH(2)) u_w2 (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .M(M), .M_prev(M_prev),
    .Clr_Ld(outs2[6]), .Clr_XA(outs2[5]), .Add(outs2[4]), .Sub(outs2[3]),
    .Shift_En(outs2[2]), .Busy(outs2[1]), .Done(outs2[0]), .Step(step2)
  );

  mult_ctrl_n #(.WIDTH(4)) u_w4 (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .M(M), .M_prev(M_prev),
    .Clr_Ld(outs4[6]), .Clr_XA(outs4[5]), .Add(outs4[4]), .Sub(outs4[3]),
    .Shift_En(outs4[2]), .Busy(outs4[1]), .Done(outs4[0]), .Step(step4)
  );

  mult_ctrl_n #(.WIDTH(8)) u_w8 (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .M(M), .M_prev(M_prev),
    .Clr_Ld(outs8[6]), .Clr_XA(outs8[5]), .Add(outs8[4]), .Sub(outs8[3]),
    .Shift_En(outs8[2]), .Busy(outs8[1]), .Done(outs8[0]), .Step(step8)
  );

  mult_ctrl_n #(.WIDTH(16)) u_w16 (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .M(M), .M_prev(M_prev),
    .Clr_Ld(outs16[6]), .Clr_XA(outs16[5]), .Add(outs16[4]), .Sub(outs16[3]),
    .Shift_En(outs16[2]), .Busy(outs16[1]), .Done(outs16[0]), .Step(step16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errs = errs + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] get_outs(input int w);
    case (w)
      2:       return outs2;
      4:       return outs4;
      8:       return outs8;
      16:      return outs16;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [31:0] get_step(input int w);
    case (w)
      2:       return {31'd0, step2};
      4:       return {30'd0, step4};
      8:       return {29'd0, step8};
      16:      return {28'd0, step16};
      default: return 32'd0;
    endcase
  endfunction

  // Expected outputs at cycle c of a run (cycle 1 = CLEAR), Run held high.
  function automatic logic [6:0] exp_outs(input int w, input int c, input logic m, input logic mp);
    int  s;
    logic a, sb;
    if (c == 1) return 7'b0100010;
    if (c <= 2 * w + 1) begin
      if ((c % 2) == 1) return 7'b0000110;
      s = (c - 2) / 2;
`ifdef MULT_CTRL_BOOTH_EN
      a  = ~m & mp;
      sb = m & ~mp;
`else
      a  = (s < w - 1) ? m : 1'b0;
      sb = (s == w - 1) ? m : 1'b0;
`endif
      return {2'b00, a, sb, 3'b010};
    end
    return 7'b0000001;
  endfunction

  function automatic logic [31:0] exp_step(input int w, input int c);
    if (c <= 2 * w) return 32'((c - 2) / 2);
    if (c == 2 * w + 1) return 32'((c - 3) / 2);
    return 32'(w - 1);
  endfunction

  task automatic idle_cycles(input int n);
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One full multiply on instance w; ClearA_LoadB raised from cycle clb_cycle (0 = never)
  task automatic do_run(input int w, input int clb_cycle, input logic [15:0] mv, input logic [15:0] mpv);
    int s;
    Run          = 1'b1;
    ClearA_LoadB = 1'b0;
    for (int c = 1; c <= 2 * w + 4; c++) begin
      @(posedge Clk);
      #1;
      ClearA_LoadB = (clb_cycle > 0 && c >= clb_cycle) ? 1'b1 : 1'b0;
      if ((c % 2) == 0 && c <= 2 * w) begin
        s      = (c - 2) / 2;
        M      = mv[s];
        M_prev = mpv[s];
      end
      #1;
      check_eq($sformatf("w%0d_c%0d_outs", w, c), {25'd0, get_outs(w)}, {25'd0, exp_outs(w, c, M, M_prev)});
      if (c > 1) begin
        check_eq($sformatf("w%0d_c%0d_step", w, c), get_step(w), exp_step(w, c));
      end
    end
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    @(posedge Clk);
    #1;
    check_eq($sformatf("w%0d_idle_outs", w), {25'd0, get_outs(w)}, 32'd0);
    check_eq($sformatf("w%0d_idle_step", w), get_step(w), 32'(w - 1));
  endtask

  initial begin
    errs         = 0;
    checks       = 0;
    Reset        = 1'b1;
    ClearA_LoadB = 1'b0;
    Run          = 1'b0;
    M            = 1'b0;
    M_prev       = 1'b0;

    // Reset state
    #1;
    check_eq("rst_gated_outs", {25'd0, outs8}, 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check_eq("rst_outs", {25'd0, outs8}, 32'd0);
    check_eq("rst_step", {29'd0, step8}, 32'd0);

    // Main multiply, WIDTH=8, M held 1
    do_run(8, 0, 16'hFFFF, 16'h0000);
    idle_cycles(40);

    // Load and Run together in IDLE: load wins, state stays IDLE
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    #1;
    check_eq("clb_run_now", {25'd0, outs8}, 32'h40);
    @(posedge Clk);
    #1;
    check_eq("clb_run_stay_idle", {25'd0, outs8}, 32'h40);

    // Run alone, load request raised mid-run is ignored, M=0 pattern
    do_run(8, 5, 16'h0000, 16'h0000);
    idle_cycles(40);

    // WIDTH extremes
    do_run(2, 0, 16'h0001, 16'h0000);
    idle_cycles(40);
    do_run(16, 0, 16'hA5A5, 16'h4B4B);
    idle_cycles(40);

    // WIDTH=4 with (M,M_prev) = 10,11,01,00 per step
    do_run(4, 0, 16'h0003, 16'h0006);
    idle_cycles(40);

    // Reset in SHIFT at Step 3
    Run = 1'b1;
    repeat (9) @(posedge Clk);
    #1;
    check_eq("mid_shift_outs", {25'd0, outs8}, 32'h06);
    check_eq("mid_shift_step", {29'd0, step8}, 32'd3);
    Reset = 1'b1;
    Run   = 1'b0;
    #1;
    check_eq("mid_rst_gated_outs", {25'd0, outs8}, 32'd0);
    check_eq("mid_rst_gated_step", {29'd0, step8}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge Clk);
      #1;
      check_eq($sformatf("mid_rst_hold%0d", k), {25'd0, outs8}, 32'd0);
    end
    Reset = 1'b0;
    #1;
    check_eq("mid_rst_idle_outs", {25'd0, outs8}, 32'd0);
    check_eq("mid_rst_idle_step", {29'd0, step8}, 32'd0);
    @(posedge Clk);
    #1;
    check_eq("mid_rst_still_idle", {25'd0, outs8}, 32'd0);
    check_eq("mid_rst_w16_idle", {25'd0, outs16}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_mult_ctrl_n
